decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, parametrised instruction-decode stage for the RV32I/RV64I core. Sits between fetch and execute.
- Decodes each accepted 32-bit instruction: fields, sign-extended XLEN immediate, format tag, illegal flag.
- Buffers decoded results in a small in-order FIFO with valid/ready handshakes on both sides.
- Supports pipeline flush.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; sets immediate and PC width.
OUT_DEPTH, 2, decoded-entry FIFO depth; power of two, >= 2.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept; equals !full
in_inst  in  32  raw instruction
in_pc  in  XLEN  instruction address
flush  in  1  discard all buffered entries and any same-cycle push
out_valid  out  1  head entry valid; equals !empty
out_ready  in  1  execute consumes head
out_opcode  out  7  inst[6:0]
out_rd  out  5  inst[11:7]
out_rs1  out  5  inst[19:15]
out_rs2  out  5  inst[24:20]
out_funct3  out  3  inst[14:12]
out_funct7  out  7  inst[31:25]
out_imm  out  XLEN  sign-extended immediate
out_fmt  out  3  format tag: NONE=0, R=1, I=2, S=3, B=4, U=5, J=6
out_pc  out  XLEN  PC of head entry
out_illegal  out  1  head instruction illegal
count  out  $clog2(OUT_DEPTH)+1  occupancy

Behaviour:
- Reset is asynchronous on rst_n low. It forces count=0, out_valid=0 and in_ready=1.
- Reset clears all entry payloads and the read/write pointers. Head outputs read 0 during reset. Asserting reset mid-stream drops all entries.
- Push occurs when in_valid && in_ready && !flush. Pop occurs when out_valid && out_ready && !flush.
- Latency: an instruction accepted at edge N appears at the head after edge N if the FIFO was empty. No combinational path from in_* to out_*.
- in_ready is derived only from count, never from out_ready. When full, no push occurs even in a popping cycle.
- Simultaneous push and pop when not full or empty: count is unchanged and both pointers advance.
- Pointers wrap modulo OUT_DEPTH.
- flush has priority over push and pop. Next cycle: count=0, out_valid=0, pending push dropped.
- Immediate selection:
  - I-type: LOAD, OP_IMM, JALR, SYSTEM.
  - S-type: STORE.
  - B-type: BRANCH, with bit0=0.
  - J-type: JAL, with bit0=0.
  - U-type: LUI, AUIPC; inst[31:12]<<12.
  - OP: R-type, imm=0.
  - Unknown opcode: NONE, imm=0.
- All immediates sign-extend from inst[31] to XLEN. This includes U-type when XLEN=64.
- out_illegal=1 when any of:
  - inst[1:0] != 2'b11;
  - opcode unknown;
  - OP with funct7 not in {0000000, 0100000};
  - OP with funct7=0100000 and funct3 not in {000, 101};
  - OP_IMM shift (funct3 001/101) with inst[31:25] (XLEN=32) or inst[31:26] (XLEN=64) not in the zero/0100000 shift encodings;
  - funct3=001 with the 0100000 encoding.
- Illegal entries are still queued normally. The fields are still reported.

Optional Feature:
- Macro: DECODE_PERF_EN.
- Defined: adds output ports perf_decoded (32) and perf_illegal (32). perf_decoded increments on each push; perf_illegal increments on each push whose instruction is illegal.
- Both counters wrap at 2^32. Both are cleared by rst_n only; flush does not clear them.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package: opcode constants (LOAD, STORE, BRANCH, JAL, JALR, OP, OP_IMM, LUI, AUIPC, SYSTEM) and format-tag constants.
- Sub-module: decode_fields. It is purely combinational (inst -> fields, imm, fmt, illegal) and parametrised by XLEN.
- decode_stage owns the FIFO storage, pointers, count and handshake logic.

Test Plan:
1. Reset and addi: pulse rst_n low while count=2 -> count=0, out_valid=0 immediately. Then push 0xFFF10093 (addi x1,x2,-1) -> next cycle out_valid=1, rd=1, rs1=2, imm=0xFFFFFFFF, fmt=I, illegal=0.
2. Jump immediate: push 0xFFDFF06F (jal x0,-4) -> imm=0xFFFFFFFC, fmt=J. With XLEN=64, push 0x800000B7 (lui x1,0x80000) -> imm=0xFFFFFFFF80000000, fmt=U.
3. Fill and drain: OUT_DEPTH=2, out_ready=0, push A,B,C back-to-back -> in_ready=0 after B, C held. Then out_ready=1 -> A, B, C pop in order, and in_ready never depends combinationally on out_ready.
4. Illegal encodings: push 0x00000000 -> illegal=1, fmt=NONE, imm=0. Push 0x40001033 -> illegal=1, fmt=R.
5. Flush: full FIFO, in_valid=1 and flush=1 in the same cycle -> next cycle count=0, out_valid=0, new instruction not queued. With DECODE_PERF_EN defined, perf counters unchanged by the dropped push.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared RV32I/RV64I decode constants: base opcodes and the format tags reported with each decoded entry.
package decode_stage_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } fmt_e;

endpackage

// File: rtl/decode_fields.sv
// Purely combinational instruction decoder: raw fields, sign-extended XLEN immediate,
// format tag and illegal flag for one 32-bit RV32I/RV64I instruction.
module decode_fields
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_u;
    logic            shift_zero;
    logic            shift_alt;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // U-type fills the upper word from inst[31] so RV64 LUI/AUIPC sign-extend too.
    always_comb begin
        imm_u       = {XLEN{inst[31]}};
        imm_u[31:0] = {inst[31:12], 12'h000};
    end

    // RV64 shamt is six bits wide, so only inst[31:26] carries the shift-type encoding.
    always_comb begin
        if (XLEN == 64) begin
            shift_zero = (inst[31:26] == 6'b000000);
            shift_alt  = (inst[31:26] == 6'b010000);
        end else begin
            shift_zero = (inst[31:25] == 7'b0000000);
            shift_alt  = (inst[31:25] == 7'b0100000);
        end
    end

    always_comb begin
        fmt     = FMT_NONE;
        imm     = '0;
        illegal = 1'b0;
        case (inst[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: begin
                fmt = FMT_I;
                imm = imm_i;
            end
            OPC_STORE: begin
                fmt = FMT_S;
                imm = imm_s;
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                imm = imm_b;
            end
            OPC_JAL: begin
                fmt = FMT_J;
                imm = imm_j;
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                imm = imm_u;
            end
            OPC_OP: begin
                fmt = FMT_R;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase

        if (inst[1:0] != 2'b11) begin
            illegal = 1'b1;
        end

        if (inst[6:0] == OPC_OP) begin
            if (inst[31:25] != 7'b0000000 && inst[31:25] != 7'b0100000) begin
                illegal = 1'b1;
            end
            if (inst[31:25] == 7'b0100000 && inst[14:12] != 3'b000 && inst[14:12] != 3'b101) begin
                illegal = 1'b1;
            end
        end

        if (inst[6:0] == OPC_OP_IMM && (inst[14:12] == 3'b001 || inst[14:12] == 3'b101)) begin
            if (!shift_zero && !shift_alt) begin
                illegal = 1'b1;
            end
            if (inst[14:12] == 3'b001 && shift_alt) begin
                illegal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes each accepted instruction into an in-order FIFO of OUT_DEPTH entries.
// Optional DECODE_PERF_EN adds perf_decoded / perf_illegal push counters.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int OUT_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [XLEN-1:0]            in_pc,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [6:0]                 out_opcode,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [2:0]                 out_funct3,
    output logic [6:0]                 out_funct7,
    output logic [XLEN-1:0]            out_imm,
    output logic [2:0]                 out_fmt,
    output logic [XLEN-1:0]            out_pc,
    output logic                       out_illegal,
    output logic [$clog2(OUT_DEPTH):0] count
`ifdef DECODE_PERF_EN
    ,
    output logic [31:0]                perf_decoded,
    output logic [31:0]                perf_illegal
`endif
);

    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUT_DEPTH);

    typedef struct packed {
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } entry_t;

    entry_t             dec;
    entry_t             head;
    entry_t             mem [OUT_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push;
    logic               pop;

    decode_fields #(.XLEN(XLEN)) u_fields (
        .inst    (in_inst),
        .opcode  (dec.opcode),
        .rd      (dec.rd),
        .rs1     (dec.rs1),
        .rs2     (dec.rs2),
        .funct3  (dec.funct3),
        .funct7  (dec.funct7),
        .imm     (dec.imm),
        .fmt     (dec.fmt),
        .illegal (dec.illegal)
    );
    assign dec.pc = in_pc;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high and
    // flush is low; in_ready depends only on occupancy, so it never follows out_ready.
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head        = mem[rd_ptr];
    assign out_opcode  = head.opcode;
    assign out_rd      = head.rd;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_funct3  = head.funct3;
    assign out_funct7  = head.funct7;
    assign out_imm     = head.imm;
    assign out_fmt     = head.fmt;
    assign out_pc      = head.pc;
    assign out_illegal = head.illegal;

`ifdef DECODE_PERF_EN
    // Counters survive flush; only rst_n clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_decoded <= '0;
            perf_illegal <= '0;
        end else begin
            if (push) begin
                perf_decoded <= perf_decoded + 32'd1;
            end
            if (push && dec.illegal) begin
                perf_illegal <= perf_illegal + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed decoded entries go into a scoreboard queue,
// a negedge monitor pops and compares every head transfer; an XLEN=64 instance covers RV64 immediates.
module tb_decode_stage;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [31:0] pc;
        logic        illegal;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic [31:0] out_pc;
    logic        out_illegal;
    logic [1:0]  count;
`ifdef DECODE_PERF_EN
    logic [31:0] perf_decoded;
    logic [31:0] perf_illegal;
    logic [31:0] snap_decoded;
    logic [31:0] snap_illegal;
`endif

    logic        v64_in_valid;
    logic        v64_in_ready;
    logic [31:0] v64_in_inst;
    logic [63:0] v64_in_pc;
    logic        v64_out_valid;
    logic        v64_out_ready;
    logic [6:0]  v64_opcode;
    logic [4:0]  v64_rd;
    logic [4:0]  v64_rs1;
    logic [4:0]  v64_rs2;
    logic [2:0]  v64_funct3;
    logic [6:0]  v64_funct7;
    logic [63:0] v64_imm;
    logic [2:0]  v64_fmt;
    logic [63:0] v64_pc;
    logic        v64_illegal;
    logic [1:0]  v64_count;
`ifdef DECODE_PERF_EN
    logic [31:0] v64_perf_decoded;
    logic [31:0] v64_perf_illegal;
`endif

    exp_t exp_q[$];
    exp_t mon_act;
    exp_t mon_exp;
    int   tests_run;
    int   tests_failed;

    localparam logic [31:0] I_ADDI  = 32'hFFF10093;
    localparam logic [31:0] I_JAL   = 32'hFFDFF06F;
    localparam logic [31:0] I_LUI   = 32'h800000B7;
    localparam logic [31:0] I_ZERO  = 32'h00000000;
    localparam logic [31:0] I_SUBSL = 32'h40001033;
    localparam logic [31:0] I_SLLIX = 32'h40309093;
    localparam logic [31:0] I_SRAI  = 32'h4030D093;
    localparam logic [31:0] I_LOW10 = 32'h00000012;
    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SW    = 32'h00512423;
    localparam logic [31:0] I_BEQ   = 32'hFE208CE3;

    decode_stage #(.XLEN(32), .OUT_DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_imm     (out_imm),
        .out_fmt     (out_fmt),
        .out_pc      (out_pc),
        .out_illegal (out_illegal),
        .count       (count)
`ifdef DECODE_PERF_EN
        ,
        .perf_decoded (perf_decoded),
        .perf_illegal (perf_illegal)
`endif
    );

    decode_stage #(.XLEN(64), .OUT_DEPTH(2)) dut64 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (v64_in_valid),
        .in_ready    (v64_in_ready),
        .in_inst     (v64_in_inst),
        .in_pc       (v64_in_pc),
        .flush       (1'b0),
        .out_valid   (v64_out_valid),
        .out_ready   (v64_out_ready),
        .out_opcode  (v64_opcode),
        .out_rd      (v64_rd),
        .out_rs1     (v64_rs1),
        .out_rs2     (v64_rs2),
        .out_funct3  (v64_funct3),
        .out_funct7  (v64_funct7),
        .out_imm     (v64_imm),
        .out_fmt     (v64_fmt),
        .out_pc      (v64_pc),
        .out_illegal (v64_illegal),
        .count       (v64_count)
`ifdef DECODE_PERF_EN
        ,
        .perf_decoded (v64_perf_decoded),
        .perf_illegal (v64_perf_illegal)
`endif
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        tests_failed++;
        $display("FAIL watchdog: got timeout expected $finish");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    function automatic exp_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] imm, input logic [2:0] fmt, input logic [31:0] pc,
                                input logic ill);
        exp_t e;
        e.opcode = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.funct3 = f3; e.funct7 = f7;
        e.imm = imm; e.fmt = fmt; e.pc = pc; e.illegal = ill;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver: call between edges; holds the instruction until accepted, then releases in_valid.
    task automatic push(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
        int n;
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("push_timeout", 64'(in_ready), 64'd1);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((out_valid || exp_q.size() != 0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic push64(input logic [31:0] inst);
        v64_in_valid = 1'b1;
        v64_in_inst  = inst;
        v64_in_pc    = 64'h1000;
        @(posedge clk); #1;
        v64_in_valid = 1'b0;
    endtask

    // Scoreboard monitor: compare every entry leaving the head
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            mon_act = mk(out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
                         out_imm, out_fmt, out_pc, out_illegal);
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_pop: got %h expected none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    tests_failed++;
                    $display("FAIL head_entry pc=%h: got %h expected %h", mon_exp.pc, mon_act, mon_exp);
                end
            end
        end
    end

    initial begin
        tests_run = 0; tests_failed = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        v64_in_valid = 1'b0; v64_in_inst = '0; v64_in_pc = '0; v64_out_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_illegal", 64'(out_illegal), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-stream with two entries buffered
        push(I_ADD, 32'h100, mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0, 3'd1, 32'h100, 1'b0));
        push(I_SW,  32'h104, mk(7'h23, 5'd8, 5'd2, 5'd5, 3'd2, 7'h00, 32'h8, 3'd3, 32'h104, 1'b0));
        chk("pre_reset_count", 64'(count), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("async_reset_count", 64'(count), 64'd0);
        chk("async_reset_out_valid", 64'(out_valid), 64'd0);
        chk("async_reset_in_ready", 64'(in_ready), 64'd1);
        chk("async_reset_head_pc", 64'(out_pc), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        push(I_ADDI, 32'h110, mk(7'h13, 5'd1, 5'd2, 5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, 3'd2, 32'h110, 1'b0));
        chk("addi_latency_out_valid", 64'(out_valid), 64'd1);
        chk("addi_imm", 64'(out_imm), 64'hFFFFFFFF);
        drain("addi_drained");

        // Back-to-back stream: jumps, U-type, illegal encodings, shift encodings
        push(I_JAL,   32'h200, mk(7'h6F, 5'd0, 5'd31, 5'd29, 3'd7, 7'h7F, 32'hFFFFFFFC, 3'd6, 32'h200, 1'b0));
        push(I_LUI,   32'h204, mk(7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'h40, 32'h80000000, 3'd5, 32'h204, 1'b0));
        push(I_ZERO,  32'h208, mk(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 3'd0, 32'h208, 1'b1));
        push(I_SUBSL, 32'h20C, mk(7'h33, 5'd0, 5'd0, 5'd0, 3'd1, 7'h20, 32'h0, 3'd1, 32'h20C, 1'b1));
        push(I_SLLIX, 32'h210, mk(7'h13, 5'd1, 5'd1, 5'd3, 3'd1, 7'h20, 32'h403, 3'd2, 32'h210, 1'b1));
        push(I_SRAI,  32'h214, mk(7'h13, 5'd1, 5'd1, 5'd3, 3'd5, 7'h20, 32'h403, 3'd2, 32'h214, 1'b0));
        push(I_LOW10, 32'h218, mk(7'h12, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 3'd0, 32'h218, 1'b1));
        drain("stream_drained");

        // Fill, hold, then drain in order
        out_ready = 1'b0;
        push(I_ADD, 32'h300, mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0, 3'd1, 32'h300, 1'b0));
        push(I_SW,  32'h304, mk(7'h23, 5'd8, 5'd2, 5'd5, 3'd2, 7'h00, 32'h8, 3'd3, 32'h304, 1'b0));
        chk("full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_inst = I_BEQ; in_pc = 32'h308;
        @(posedge clk); #1;
        chk("full_hold_count", 64'(count), 64'd2);
        out_ready = 1'b1;
        #1;
        chk("in_ready_ignores_out_ready", 64'(in_ready), 64'd0);
        push(I_BEQ, 32'h308, mk(7'h63, 5'd25, 5'd1, 5'd2, 3'd0, 7'h7F, 32'hFFFFFFF8, 3'd4, 32'h308, 1'b0));
        drain("fill_drained");

        // Flush a full FIFO while a push is offered
        out_ready = 1'b0;
        push(I_ADD, 32'h400, mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0, 3'd1, 32'h400, 1'b0));
        push(I_SW,  32'h404, mk(7'h23, 5'd8, 5'd2, 5'd5, 3'd2, 7'h00, 32'h8, 3'd3, 32'h404, 1'b0));
        chk("pre_flush_count", 64'(count), 64'd2);
`ifdef DECODE_PERF_EN
        snap_decoded = perf_decoded;
        snap_illegal = perf_illegal;
`endif
        in_valid = 1'b1; in_inst = I_ADDI; in_pc = 32'h408; flush = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("flush_push_dropped", 64'(out_valid), 64'd0);
`ifdef DECODE_PERF_EN
        chk("flush_perf_decoded", 64'(perf_decoded), 64'(snap_decoded));
        chk("flush_perf_illegal", 64'(perf_illegal), 64'(snap_illegal));
`endif
        push(I_ADDI, 32'h40C, mk(7'h13, 5'd1, 5'd2, 5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, 3'd2, 32'h40C, 1'b0));
        drain("post_flush_drained");

        // RV64 immediates
        push64(I_LUI);
        chk("rv64_lui_valid", 64'(v64_out_valid), 64'd1);
        chk("rv64_lui_imm", v64_imm, 64'hFFFFFFFF80000000);
        chk("rv64_lui_fmt", 64'(v64_fmt), 64'd5);
        chk("rv64_lui_illegal", 64'(v64_illegal), 64'd0);
        push64(I_JAL);
        chk("rv64_jal_imm", v64_imm, 64'hFFFFFFFFFFFFFFFC);
        chk("rv64_jal_fmt", 64'(v64_fmt), 64'd6);
        push64(I_SLLIX);
        chk("rv64_slli_alt_illegal", 64'(v64_illegal), 64'd1);

        repeat (3) @(posedge clk); #1;
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
